// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic-array result drain.
// Build option: SYSTOLIC_DRAIN_RELU_EN (see systolic_result_drain.sv).
package systolic_pkg;

  localparam int DATA_W_DEFAULT = 8;

  // One quantised result element as produced by the array.
  typedef logic signed [7:0] elem_t;

  // IDLE: nothing held. DRAIN: a matrix is held and rows are being emitted.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

endpackage : systolic_pkg

// File: rtl/drain_relu.sv
// Per-element ReLU clamp applied on the output path of the result drain.
// Negative values (sign bit set) become zero; others pass unchanged.
module drain_relu
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] i_elem,
  output logic [DATA_W-1:0] o_elem
);

  // Clamp on the sign bit.
  always_comb begin
    o_elem = i_elem[DATA_W-1] ? '0 : i_elem;
  end

endmodule : drain_relu

// File: rtl/systolic_result_drain.sv
// Captures the N x N result matrix of the systolic array on its valid pulse
// and streams it out one row per beat over a valid/ready interface.
// A pulse that arrives while a matrix is still draining is dropped and
// recorded in the sticky overrun flag.
// Build option: define SYSTOLIC_DRAIN_RELU_EN to clamp negative output
// elements to zero; the capture buffer always keeps the raw values.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int FCNT_W = 16
) (
  input  logic                             i_clk,
  input  logic                             i_srstn,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]  i_c,
  input  logic                             i_validResult,
  output logic [N-1:0][DATA_W-1:0]         o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_last,
  output logic [$clog2(N)-1:0]             o_rowIdx,
  output logic                             o_busy,
  output logic                             o_overrun,
  input  logic                             i_clrOverrun,
  output logic [FCNT_W-1:0]                o_frameCnt
);

  localparam int ROW_W = $clog2(N);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

  drain_state_t                    state_q;
  logic [N-1:0][N-1:0][DATA_W-1:0] buf_q;
  logic [ROW_W-1:0]                row_q;
  logic                            valid_q;
  logic                            last_q;
  logic                            overrun_q;
  logic                            overrun_d;
  logic [FCNT_W-1:0]               fcnt_q;
  logic [FCNT_W-1:0]               fcnt_d;

  logic                            xfer;
  logic                            final_xfer;
  logic                            accept;
  logic                            drop;
  logic [N-1:0][DATA_W-1:0]        row_sel;

  // Handshake decode: which pulses are taken, which are dropped, and the
  // next value of the sticky flag and the frame counter.
  always_comb begin
    // NOTE: every signal gets a value before any condition so no latch is inferred.
    xfer       = valid_q & i_ready;
    final_xfer = xfer & last_q;
    // A new matrix fits only when nothing is held, or when the last row of
    // the held matrix leaves in this very cycle (no bubble between frames).
    accept     = i_validResult & ((state_q == IDLE) | final_xfer);
    drop       = i_validResult & ~accept;
    // Clear first, then set, so a coincident drop is never lost.
    overrun_d  = drop | (overrun_q & ~i_clrOverrun);
    fcnt_d     = final_xfer ? fcnt_q + 1'b1 : fcnt_q;
  end

  // Drain FSM with capture buffer, row pointer and registered stream flags.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!i_srstn) begin
      state_q   <= IDLE;
      // NOTE: the buffer is reset on purpose so o_data reads zero after reset.
      buf_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      overrun_q <= overrun_d;
      fcnt_q    <= fcnt_d;
      if (accept) begin
        buf_q <= i_c;
      end
      case (state_q)
        IDLE: begin
          if (i_validResult) begin
            state_q <= DRAIN;
            valid_q <= 1'b1;
            row_q   <= '0;
            last_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (last_q) begin
              row_q  <= '0;
              last_q <= 1'b0;
              if (!i_validResult) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
              end
            end else begin
              row_q  <= row_q + 1'b1;
              last_q <= (row_q == LAST_ROW - 1'b1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Present the held row selected by the registered row pointer.
  always_comb begin
    row_sel = buf_q[row_q];
  end

`ifdef SYSTOLIC_DRAIN_RELU_EN
  for (genvar g = 0; g < N; g++) begin : g_relu
    drain_relu #(
      .DATA_W(DATA_W)
    ) u_relu (
      .i_elem(row_sel[g]),
      .o_elem(o_data[g])
    );
  end
`else
  assign o_data = row_sel;
`endif

  assign o_valid    = valid_q;
  assign o_busy     = valid_q;
  assign o_last     = last_q;
  assign o_rowIdx   = row_q;
  assign o_overrun  = overrun_q;
  assign o_frameCnt = fcnt_q;

endmodule : systolic_result_drain
